// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word in, MSB-first bit stream out with frame strobe.
// Optional even-parity trailer bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             do_o,
  output logic             frame_o,
  output logic             busy_o
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_q, do_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             load;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q, par_d;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  // Ready opens on the final cycle of a word so the next one follows with no gap.
`ifdef PISO_SERIALIZER_PARITY_EN
  assign in_ready_o = rst_n_i && ((state_q == IDLE) || (state_q == PARITY));
`else
  assign in_ready_o = rst_n_i && ((state_q == IDLE) || last_bit);
`endif

  assign load = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          shreg_d = in_data_i;
          cnt_d   = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
          par_d   = ^in_data_i;
`endif
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
          shreg_d = '0;
`else
          if (load) begin
            state_d = SHIFT;
            shreg_d = in_data_i;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (load) begin
          state_d = SHIFT;
          shreg_d = in_data_i;
          cnt_d   = '0;
          par_d   = ^in_data_i;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    do_d    = 1'b0;
    frame_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      SHIFT: begin
        do_d    = shreg_d[WIDTH-1];
        frame_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        do_d    = par_q;
        frame_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      do_q    <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign do_o    = do_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words expand into an expected bit queue that a
// negedge monitor drains against do/frame/busy/in_ready.
module tb_piso_serializer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, dout, frame, busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_cnt   = 0;
  bit   started  = 1'b0;
  logic exp_q[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .do_o       (dout),
    .frame_o    (frame),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: a word is taken whenever nothing remains to send after the current cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1'b1;
      exp_q.delete();
    end else if (in_valid && exp_q.size() == 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(in_data[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
      exp_q.push_back(^in_data);
`endif
      hs_cnt++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic ef, er, b;
      ef = (exp_q.size() != 0);
      er = rst_n && (exp_q.size() <= 1);
      chk("frame", frame, ef);
      chk("busy", busy, ef);
      chk("in_ready", in_ready, er);
      if (ef) begin
        b = exp_q.pop_front();
        chk("do_bit", dout, b);
      end else begin
        chk("do_idle", dout, 1'b0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a word and wait (bounded) until the model records its acceptance; leaves in_valid high.
  task automatic put(input logic [WIDTH-1:0] d);
    int start, t;
    in_valid = 1'b1;
    in_data  = d;
    start    = hs_cnt;
    t        = 0;
    while (hs_cnt == start && t < 100) begin
      cyc(1);
      t++;
    end
    n_checks++;
    if (hs_cnt == start) begin
      n_errors++;
      $display("FAIL handshake_timeout at %0t: word %h not accepted in 100 cycles", $time, d);
    end
  endtask

  task automatic drain(input int extra);
    int t;
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cyc(1);
      t++;
    end
    cyc(extra);
  endtask

  initial begin
    // Reset with a word on offer: nothing may be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    cyc(3);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    cyc(2);

    put(8'hA5);
    drain(3);

    put(8'h81);
    put(8'h3C);
    drain(3);

    // Stall: second word arrives 4 idle cycles after the first ends.
    put(8'h5A);
    drain(4);
    put(8'hC3);
    drain(2);

    // Reset mid-word after four bits, then a clean word.
    put(8'hF0);
    in_valid = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    put(8'h0F);
    drain(2);

    put(8'h07);
    drain(1);
    put(8'h03);
    drain(2);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = WIDTH'($urandom);
      cyc(1);
    end
    rst_n = 1'b1;
    drain(5);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_drain: %0d bits still expected, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
